// File: rtl/alu_result_stage_if.sv
// Bus between the ALU, the result stage and writeback: push side, writeback side,
// and the status/branch-condition outputs.
interface alu_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] ALU_OUT;
  logic [5:0]       ALU_FLAGS;
  logic [3:0]       SEL;
  logic [WIDTH-1:0] IN2;
  logic [RD_W-1:0]  DEST;
  logic             FLAG_WE;
  logic             WB_VALID;
  logic             WB_READY;
  logic [WIDTH-1:0] WB_DATA;
  logic [RD_W-1:0]  WB_DEST;
  logic             WB_EXC;
  logic [2:0]       COND;
  logic             TAKEN;
  logic [5:0]       FLAGS_Q;
  logic [7:0]       EXC_CNT;

  modport master (
    output IN_VALID, ALU_OUT, ALU_FLAGS, SEL, IN2, DEST, FLAG_WE, WB_READY, COND,
    input  IN_READY, WB_VALID, WB_DATA, WB_DEST, WB_EXC, TAKEN, FLAGS_Q, EXC_CNT
  );

  modport slave (
    input  IN_VALID, ALU_OUT, ALU_FLAGS, SEL, IN2, DEST, FLAG_WE, WB_READY, COND,
    output IN_READY, WB_VALID, WB_DATA, WB_DEST, WB_EXC, TAKEN, FLAGS_Q, EXC_CNT
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry in-order writeback FIFO with divide-by-zero trapping,
// status register update at push time, branch-condition evaluation and exception count.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input logic             CLK,
  input logic             RST_N,
  alu_result_stage_if.slave bus
);

  localparam logic [3:0] SEL_DIV = 4'b0011;
  localparam logic [3:0] SEL_MOD = 4'b0100;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [RD_W-1:0]  dest;
    logic             exc;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  function automatic logic div_by_zero(input logic [3:0] sel, input logic [WIDTH-1:0] in2);
    return ((sel == SEL_DIV) || (sel == SEL_MOD)) && (in2 == '0);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // Flag order is {Z,S,P,G,E,L}
  function automatic logic cond_taken(input logic [5:0] flags, input logic [2:0] cond);
    logic t;
    case (cond)
      3'b000:  t = 1'b1;
      3'b001:  t = flags[5];
      3'b010:  t = ~flags[5];
      3'b011:  t = flags[4];
      3'b100:  t = flags[2];
      3'b101:  t = flags[0];
      3'b110:  t = flags[1];
      default: t = flags[3];
    endcase
    return t;
  endfunction

  state_t      state_q, state_d;
  entry_t      head_p0, tail_p0;
  entry_t      new_entry;
  logic [5:0]  flags_q;
  logic [7:0]  exc_cnt_q;
  logic        in_ready, wb_valid;
  logic        push, pop, exc_in;
  logic        head_load_new, head_load_tail, tail_load_new;

  // Ready and valid depend only on registered occupancy, never on WB_READY.
  assign in_ready = (state_q != S_FULL);
  assign wb_valid = (state_q != S_EMPTY);
  assign push     = bus.IN_VALID & in_ready;
  assign pop      = wb_valid & bus.WB_READY;
  assign exc_in   = div_by_zero(bus.SEL, bus.IN2);

  always_comb begin
    new_entry.data = exc_in ? '0 : bus.ALU_OUT;
    new_entry.dest = bus.DEST;
    new_entry.exc  = exc_in;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    head_load_new  = 1'b0;
    head_load_tail = 1'b0;
    tail_load_new  = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          head_load_new = 1'b1;
          state_d       = S_ONE;
        end
      end
      S_ONE: begin
        // Push with pop replaces the head; occupancy stays at one.
        if (push && pop) begin
          head_load_new = 1'b1;
        end else if (push) begin
          tail_load_new = 1'b1;
          state_d       = S_FULL;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          head_load_tail = 1'b1;
          state_d        = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // ---- storage stage: head feeds writeback directly ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_p0 <= '0;
      tail_p0 <= '0;
    end else begin
      if (head_load_new)       head_p0 <= new_entry;
      else if (head_load_tail) head_p0 <= tail_p0;
      if (tail_load_new)       tail_p0 <= new_entry;
    end
  end

  // ---- status stage: updated at push time regardless of writeback ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flags_q   <= '0;
      exc_cnt_q <= '0;
    end else if (push) begin
      if (bus.FLAG_WE && !exc_in) flags_q <= bus.ALU_FLAGS;
      if (exc_in)                 exc_cnt_q <= sat_inc(exc_cnt_q);
    end
  end

  assign bus.IN_READY = in_ready;
  assign bus.WB_VALID = wb_valid;
  assign bus.WB_DATA  = head_p0.data;
  assign bus.WB_DEST  = head_p0.dest;
  assign bus.WB_EXC   = head_p0.exc;
  assign bus.FLAGS_Q  = flags_q;
  assign bus.EXC_CNT  = exc_cnt_q;
  assign bus.TAKEN    = cond_taken(flags_q, bus.COND);

endmodule
